if_fetch_stage: RTL

- Instruction-fetch stage of the P5 five-stage MIPS pipeline.
- Owns the PC register and issues fetch requests to instruction memory over a req/ack handshake.
- Loads the IF/ID pipeline register.
- Takes its next-PC target from the ID-stage next-PC unit (jump/branch target, or PC+8 for not-taken), honouring the architectural delay slot. Redirects that arrive while a fetch is outstanding are buffered.

---
 rtl/if_fetch_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// IF stage of the P5 MIPS pipeline: PC register, req/ack fetch, IF/ID register.
// Define FETCH_ALIGN_CHK_EN to trap misaligned PCs (adds the ifid_adel port).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        pc_sel,
  input  logic        stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic        ifid_adel
`endif
);

  typedef enum logic {S_REQ, S_HELD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] redir_q, redir_d;
  logic        redir_full_q, redir_full_d;

  logic [31:0] pc_plus4;
  logic [31:0] live_tgt, buf_tgt, next_pc;
  logic        live_redir, misalign, fetch_ok;
  logic [31:0] fetch_word;
  logic        deliver_live, deliver_hold, bubble, capture_hold, pc_upd;

  assign pc_plus4   = pc_q + 32'd4;
  assign live_redir = pc_sel & ~stall & valid_q;

`ifdef FETCH_ALIGN_CHK_EN
  assign misalign = (pc_q[1:0] != 2'b00);
  assign live_tgt = npc_in;
  assign buf_tgt  = redir_q;
`else
  assign misalign = 1'b0;
  assign live_tgt = npc_in  & 32'hFFFF_FFFC;
  assign buf_tgt  = redir_q & 32'hFFFF_FFFC;
`endif

  // A misaligned PC is serviced locally as an instant NOP fetch, never reaching memory.
  assign fetch_ok   = im_ack | misalign;
  assign fetch_word = misalign ? NOP_WORD : im_rdata;

  assign im_req  = reset & (state_q == S_REQ) & ~misalign;
  assign im_addr = pc_q;

  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;

  always_comb begin
    if (live_redir)        next_pc = live_tgt;
    else if (redir_full_q) next_pc = buf_tgt;
    else                   next_pc = pc_plus4;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    hold_d       = hold_q;
    redir_d      = redir_q;
    redir_full_d = redir_full_q;
    deliver_live = 1'b0;
    deliver_hold = 1'b0;
    bubble       = 1'b0;
    capture_hold = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (fetch_ok && !stall) begin
          deliver_live = 1'b1;
          instr_d      = fetch_word;
          pc4_d        = pc_plus4;
          valid_d      = 1'b1;
        end else if (fetch_ok) begin
          capture_hold = 1'b1;
          hold_d       = fetch_word;
          state_d      = S_HELD;
        end else if (!stall) begin
          bubble  = 1'b1;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end
      S_HELD: begin
        if (!stall) begin
          deliver_hold = 1'b1;
          instr_d      = hold_q;
          pc4_d        = pc_plus4;
          valid_d      = 1'b1;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    pc_upd = deliver_live | deliver_hold;

    // A branch that leaves ID before its delay slot is fetched parks its target here.
    if (pc_upd) begin
      pc_d         = next_pc;
      redir_full_d = 1'b0;
    end else if (live_redir) begin
      redir_d      = npc_in;
      redir_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_WORD;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
      hold_q       <= '0;
      redir_q      <= '0;
      redir_full_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      hold_q       <= hold_d;
      redir_q      <= redir_d;
      redir_full_q <= redir_full_d;
    end
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic adel_q, adel_d;
  logic hold_adel_q, hold_adel_d;

  always_comb begin
    adel_d      = adel_q;
    hold_adel_d = hold_adel_q;
    if (deliver_live)      adel_d = misalign;
    else if (deliver_hold) adel_d = hold_adel_q;
    else if (bubble)       adel_d = 1'b0;
    if (capture_hold)      hold_adel_d = misalign;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adel_q      <= 1'b0;
      hold_adel_q <= 1'b0;
    end else begin
      adel_q      <= adel_d;
      hold_adel_q <= hold_adel_d;
    end
  end

  assign ifid_adel = adel_q;
`endif

endmodule
